// File: rtl/hazard_ctrl.sv
// Hazard controller beside decode: drives PC / IF/ID / ID/EX enables and flushes for
// load-use stalls, taken-branch squashes and multi-cycle mult/div holds, with perf counters.
module hazard_ctrl #(
   parameter int REG_W  = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             idex_mem_read,
   input  logic [REG_W-1:0] idex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_muldiv_start,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             muldiv_busy,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int MD_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MD_WAIT = 1'b1;

   logic [0:0]      state;
   logic [MD_W-1:0] md_cnt;
   logic            lu;

   // Register 0 is hardwired zero, so a load "to" r0 never creates a dependency.
   assign lu = idex_mem_read && (idex_rt != '0) &&
               ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      muldiv_busy = 1'b0;
      if (!reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (state == MD_WAIT) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         muldiv_busy = 1'b1;
      end else if (ex_branch_taken) begin
         // Squash both younger instructions; any load-use dependent is among them.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (lu) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         md_cnt      <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (!pc_write && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  if (flush_count != '1)
                     flush_count <= flush_count + CNT_W'(1);
               end else if (ex_muldiv_start) begin
                  state  <= MD_WAIT;
                  md_cnt <= MD_W'(MD_LAT - 1);
               end
            end
            default: begin
               md_cnt <= md_cnt - MD_W'(1);
               if (md_cnt == MD_W'(1))
                  state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-level model tracking remaining hold cycles and saturating counts.
module tb_hazard_ctrl;

   localparam int MD_LAT = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, idex_rt;
   logic       id_uses_rt, idex_mem_read, ex_branch_taken, ex_muldiv_start;
   logic       pc_write, ifid_write, idex_write, ifid_flush, idex_flush, muldiv_busy;
   logic       pc_write2, ifid_write2, idex_write2, ifid_flush2, idex_flush2, muldiv_busy2;
   logic [15:0] stall_count, flush_count;
   logic [1:0]  stall_count2, flush_count2;
   logic [5:0]  obs, obs2, e_out;

   int checks = 0;
   int failures = 0;
   int m_rem, m_stall, m_flush, m_stall2, m_flush2;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(5), .MD_LAT(MD_LAT), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
      .ex_muldiv_start(ex_muldiv_start), .pc_write(pc_write), .ifid_write(ifid_write),
      .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .muldiv_busy(muldiv_busy), .stall_count(stall_count), .flush_count(flush_count));

   hazard_ctrl #(.REG_W(5), .MD_LAT(MD_LAT), .CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
      .ex_muldiv_start(ex_muldiv_start), .pc_write(pc_write2), .ifid_write(ifid_write2),
      .idex_write(idex_write2), .ifid_flush(ifid_flush2), .idex_flush(idex_flush2),
      .muldiv_busy(muldiv_busy2), .stall_count(stall_count2), .flush_count(flush_count2));

   assign obs  = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, muldiv_busy};
   assign obs2 = {pc_write2, ifid_write2, idex_write2, ifid_flush2, idex_flush2, muldiv_busy2};

   // Expected outputs {pc, ifid, idex, ifid_flush, idex_flush, busy} from the rules.
   task automatic model_eval;
      bit dep;
      dep = idex_mem_read && idex_rt != 0 &&
            (idex_rt == id_rs || (id_uses_rt && idex_rt == id_rt));
      if (!reset)               e_out = 6'b000110;
      else if (m_rem > 0)       e_out = 6'b000001;
      else if (ex_branch_taken) e_out = 6'b111110;
      else if (dep)             e_out = 6'b001010;
      else                      e_out = 6'b111000;
   endtask

   task automatic tick;
      model_eval();
      @(posedge clk);
      if (!reset) begin
         m_rem = 0; m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
      end else begin
         if (!e_out[5]) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall2 < 3) m_stall2++;
         end
         if (m_rem > 0) m_rem--;
         else if (ex_branch_taken) begin
            if (m_flush < 65535) m_flush++;
            if (m_flush2 < 3) m_flush2++;
         end else if (ex_muldiv_start) m_rem = MD_LAT - 1;
      end
      #1;
   endtask

   task automatic idle_inputs;
      id_rs = 0; id_rt = 0; idex_rt = 0; id_uses_rt = 0;
      idex_mem_read = 0; ex_branch_taken = 0; ex_muldiv_start = 0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 0;
      tick(); tick();
      reset = 1;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 0;
      tick();
      #1;
      checks++;
      if (obs !== 6'b000110) begin failures++; $display("FAIL reset_out got=%b exp=000110", obs); end
      tick();
      reset = 1;
      #1;
      checks++;
      if (obs !== 6'b111000) begin failures++; $display("FAIL reset_release got=%b exp=111000", obs); end
      checks++;
      if (stall_count !== 0 || flush_count !== 0) begin
         failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", stall_count, flush_count);
      end
   endtask

   task automatic test_load_use;
      do_reset();
      idex_mem_read = 1; idex_rt = 5; id_rs = 5;
      #1;
      checks++;
      if (obs !== 6'b001010) begin failures++; $display("FAIL lu_stall got=%b exp=001010", obs); end
      tick();
      idex_mem_read = 0;
      #1;
      checks++;
      if (obs !== 6'b111000) begin failures++; $display("FAIL lu_release got=%b exp=111000", obs); end
      checks++;
      if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
      tick();
   endtask

   task automatic test_no_false_stall;
      do_reset();
      idex_mem_read = 1; idex_rt = 0; id_rs = 0;
      #1;
      checks++;
      if (obs !== 6'b111000) begin failures++; $display("FAIL r0_stall got=%b exp=111000", obs); end
      tick();
      idex_rt = 5; id_rt = 5; id_rs = 3; id_uses_rt = 0;
      #1;
      checks++;
      if (obs !== 6'b111000) begin failures++; $display("FAIL rt_unused got=%b exp=111000", obs); end
      id_uses_rt = 1;
      #1;
      checks++;
      if (obs !== 6'b001010) begin failures++; $display("FAIL rt_used got=%b exp=001010", obs); end
      tick();
   endtask

   task automatic test_branch_lu;
      do_reset();
      idex_mem_read = 1; idex_rt = 7; id_rs = 7; ex_branch_taken = 1;
      #1;
      checks++;
      if (obs !== 6'b111110) begin failures++; $display("FAIL br_over_lu got=%b exp=111110", obs); end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (flush_count !== 16'd1 || stall_count !== 16'd0) begin
         failures++; $display("FAIL br_counts got=%0d/%0d exp=1/0", flush_count, stall_count);
      end
   endtask

   task automatic test_muldiv;
      int busy_cycles;
      do_reset();
      ex_muldiv_start = 1;
      #1;
      checks++;
      if (obs !== 6'b111000) begin failures++; $display("FAIL md_start got=%b exp=111000", obs); end
      tick();
      ex_muldiv_start = 0;
      busy_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         ex_branch_taken = (i == 1);
         #1;
         if (muldiv_busy) begin
            busy_cycles++;
            checks++;
            if (obs !== 6'b000001) begin failures++; $display("FAIL md_hold got=%b exp=000001", obs); end
         end
         tick();
      end
      ex_branch_taken = 0;
      checks++;
      if (busy_cycles != MD_LAT - 1) begin
         failures++; $display("FAIL md_len got=%0d exp=%0d", busy_cycles, MD_LAT - 1);
      end
      checks++;
      if (stall_count !== 16'd3 || flush_count !== 16'd0) begin
         failures++; $display("FAIL md_counts got=%0d/%0d exp=3/0", stall_count, flush_count);
      end
   endtask

   task automatic test_reset_mid_md;
      do_reset();
      ex_muldiv_start = 1;
      tick();
      ex_muldiv_start = 0;
      tick();
      reset = 0;
      #1;
      checks++;
      if (obs !== 6'b000110) begin failures++; $display("FAIL md_reset_out got=%b exp=000110", obs); end
      tick();
      reset = 1;
      #1;
      checks++;
      if (obs !== 6'b111000 || stall_count !== 0 || flush_count !== 0) begin
         failures++; $display("FAIL md_reset_after got=%b/%0d/%0d exp=111000/0/0", obs, stall_count, flush_count);
      end
   endtask

   task automatic test_saturation;
      do_reset();
      idex_mem_read = 1; idex_rt = 9; id_rs = 9;
      repeat (5) tick();
      idex_mem_read = 1; ex_branch_taken = 1;
      repeat (5) tick();
      idle_inputs();
      #1;
      checks++;
      if (stall_count2 !== 2'd3 || stall_count !== 16'd5) begin
         failures++; $display("FAIL sat_stall got=%0d/%0d exp=3/5", stall_count2, stall_count);
      end
      checks++;
      if (flush_count2 !== 2'd3 || flush_count !== 16'd5) begin
         failures++; $display("FAIL sat_flush got=%0d/%0d exp=3/5", flush_count2, flush_count);
      end
   endtask

   task automatic test_random;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset           = ($urandom_range(0, 39) != 0);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         idex_rt         = 5'($urandom_range(0, 3));
         id_uses_rt      = 1'($urandom);
         idex_mem_read   = 1'($urandom);
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         ex_muldiv_start = ($urandom_range(0, 7) == 0);
         #1;
         model_eval();
         checks++;
         if (obs !== e_out || obs2 !== e_out) begin
            failures++; $display("FAIL rand_out cyc=%0d got=%b/%b exp=%b", i, obs, obs2, e_out);
         end
         checks++;
         if (stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush) ||
             stall_count2 !== 2'(m_stall2) || flush_count2 !== 2'(m_flush2)) begin
            failures++;
            $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i,
                     stall_count, flush_count, stall_count2, flush_count2,
                     m_stall, m_flush, m_stall2, m_flush2);
         end
         tick();
      end
   endtask

   initial begin
      m_rem = 0; m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
      idle_inputs();
      reset = 0;
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_branch_lu();
      test_muldiv();
      test_reset_mid_md();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
